rx_interrupt_gen_mc: RTL and testbench
======================================

# rx_interrupt_gen_mc

Multi-channel, parametrised successor to the single-queue Rx interrupt generator. It sits between the per-queue Rx DMA engines and the PCIe endpoint's legacy/MSI configuration interrupt port. Each channel has its own activity detection, enable gating, hold-off (moderation) timer and resend request. A round-robin arbiter serialises the channels onto the single `cfg_interrupt_n`/`cfg_interrupt_rdy_n` handshake, with the channel index presented as the MSI vector.

## Interface
Parameters:
- `NUM_CH`, 4: number of Rx channels (1..8).
- `CNT_W`, 32: width of the hold-off counter and `interrupt_period`.
- `SYNC_STAGES`, 2: register stages on each `ch_activity` bit (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `cfg_interrupt_n` out 1: active-low interrupt request to the endpoint.
- `cfg_interrupt_rdy_n` in 1: active-low acceptance from the endpoint.
- `cfg_interrupt_di` out 8: vector; `{zero-pad, granted channel index}`.
- `ch_activity` in NUM_CH: per-channel Rx activity level.
- `ch_notify` in NUM_CH: per-channel pulse (huge-page change or qword-count update acknowledged).
- `ch_buf_ready` in NUM_CH: host buffer status; an interrupt is useful only when high.
- `ch_mask` in NUM_CH: per-channel mask, 1 = suppress.
- `interrupts_enabled` in 1: global enable.
- `interrupt_period` in CNT_W: hold-off length in clocks; shared by all channels.
- `resend_interrupt` in NUM_CH: per-channel forced-resend request level.
- `resend_interrupt_ack` out NUM_CH: one-cycle ack pulse per channel.

## Operation
- Per-channel FSM states: IDLE, PEND, PEND_FORCE, HOLDOFF.
- In IDLE, priority order:
  - `resend_interrupt[i]`: pulse `resend_interrupt_ack[i]`, go to PEND_FORCE.
  - Otherwise, a synced `ch_activity[i]` or `ch_notify[i]`: if `interrupts_enabled & ~ch_mask[i] & ch_buf_ready[i]`, go to PEND; else go to HOLDOFF.
- PEND: wait for grant. If `interrupts_enabled` falls or `ch_mask[i]` rises before grant, go to HOLDOFF with no interrupt.
- PEND_FORCE: ignores `ch_buf_ready` and `ch_mask`. It waits while `interrupts_enabled` is low and is never dropped.
- Arbiter states: ARB_IDLE, ARB_ASSERT.
  - In ARB_IDLE, grant the first requesting channel (PEND or PEND_FORCE) searching upward from last_grant+1 mod NUM_CH.
  - On grant, drive `cfg_interrupt_n`=0 and `cfg_interrupt_di`=index, then move to ARB_ASSERT.
  - In ARB_ASSERT, when `cfg_interrupt_rdy_n`=0 is sampled: drive `cfg_interrupt_n`=1, update last_grant, move the granted channel to HOLDOFF, return to ARB_IDLE.
  - Once asserted, a request is held until accepted, whatever the enable or mask state.
- HOLDOFF:
  - Counter is cleared on entry and `interrupt_period` is latched on entry.
  - Counter increments each cycle; when counter == latched period, go to IDLE. Hold-off therefore lasts period+1 cycles; period=0 gives 1 cycle.
  - Events during HOLDOFF are not queued. A level still high on return to IDLE retriggers.
- Simultaneous events:
  - Resend and activity in the same cycle: resend wins.
  - Multiple pending channels: one grant per handshake, in round-robin order.
- Reset, including mid-handshake:
  - All channels go to IDLE, arbiter to ARB_IDLE, last_grant = NUM_CH-1.
  - Synchronisers are cleared.
  - Outputs: `cfg_interrupt_n`=1, `cfg_interrupt_di`=0, `resend_interrupt_ack`=0.

## Timing
- `ch_activity` passes through SYNC_STAGES flops before the FSM sees it. `ch_notify` is used directly.
- Latency with SYNC_STAGES=2: activity high at edge 0 → PEND after edge 3 → `cfg_interrupt_n` low after edge 4.
- `ch_notify` at edge 0 → PEND after edge 1 → request after edge 2.
- `rdy_n` sampled low at edge M → `cfg_interrupt_n` high after edge M. The earliest next request is after edge M+1, so there is at least one idle cycle between requests.
- `resend_interrupt_ack` is high for exactly the cycle after the sampling edge.

## Configuration
- Macro `RX_INTR_COALESCE_EN`.
- Defined:
  - Adds input `coalesce_threshold`, width 8.
  - Adds a per-channel 8-bit count of synced `ch_activity` rising edges during HOLDOFF.
  - When that count reaches a non-zero threshold, HOLDOFF ends early and goes to IDLE on the next cycle.
  - The count clears on HOLDOFF entry and saturates at 255. A threshold of 0 disables early exit.
- Undefined: no port, no counters; hold-off is timer-only.

## Structure
- Package `rx_intr_pkg`:
  - Channel-state and arbiter-state localparams, one-hot as the codebase's FSM encoding.
  - Vector width constant, 8.
- One sub-module `rx_intr_chan`, instantiated NUM_CH times with a generate loop. It contains the per-channel synchroniser, FSM, hold-off counter and optional coalesce counter.
- The top level holds the arbiter and output registers.

## Test plan
- NUM_CH=4, period=10, ch 1 activity pulse (1 cycle), all ready/enabled → `cfg_interrupt_n` low 4 cycles later, di=1. Then rdy_n low 2 cycles later → next ch 1 interrupt no earlier than 11 cycles after acceptance.
- Ch 0, 2 and 3 pending simultaneously with last_grant=2 → grant order 3, 0, 2, with one idle cycle between requests.
- `ch_buf_ready[1]`=0 with activity → no interrupt; ch 1 still spends period+1 cycles in HOLDOFF.
- `resend_interrupt[2]` with `interrupts_enabled`=0 → ack pulse next cycle, no request. Raise enable → request with di=2.
- `interrupts_enabled` drops while ARB_ASSERT and rdy_n stays high for 20 cycles → `cfg_interrupt_n` held low until rdy_n. Reset asserted mid-handshake → `cfg_interrupt_n`=1 next cycle.
- With `RX_INTR_COALESCE_EN`, threshold=3, period=1000: three rising edges in HOLDOFF → IDLE on the following cycle. A retriggering level gives a new interrupt about 1000 cycles early.

Source files
------------

// File: rtl/rx_interrupt_gen_mc_pkg.sv
// Shared encodings for the multi-channel Rx interrupt generator: one-hot channel and arbiter states, MSI vector width.
package rx_intr_pkg;

   localparam int VEC_W = 8;

   localparam logic [3:0] CH_IDLE       = 4'b0001;
   localparam logic [3:0] CH_PEND       = 4'b0010;
   localparam logic [3:0] CH_PEND_FORCE = 4'b0100;
   localparam logic [3:0] CH_HOLDOFF    = 4'b1000;

   localparam logic [1:0] ARB_IDLE_ENC   = 2'b01;
   localparam logic [1:0] ARB_ASSERT_ENC = 2'b10;

   typedef enum logic [3:0] {
      IDLE       = CH_IDLE,
      PEND       = CH_PEND,
      PEND_FORCE = CH_PEND_FORCE,
      HOLDOFF    = CH_HOLDOFF
   } ch_state_e;

   typedef enum logic [1:0] {
      ARB_IDLE   = ARB_IDLE_ENC,
      ARB_ASSERT = ARB_ASSERT_ENC
   } arb_state_e;

endpackage

// File: rtl/rx_interrupt_gen_mc_if.sv
// Endpoint configuration-interrupt handshake: active-low request/accept plus MSI vector.
interface rx_interrupt_gen_mc_if;
   import rx_intr_pkg::*;

   logic             cfg_interrupt_n;
   logic             cfg_interrupt_rdy_n;
   logic [VEC_W-1:0] cfg_interrupt_di;

   modport master (output cfg_interrupt_n, output cfg_interrupt_di, input cfg_interrupt_rdy_n);
   modport slave  (input cfg_interrupt_n, input cfg_interrupt_di, output cfg_interrupt_rdy_n);

endinterface

// File: rtl/rx_interrupt_gen_mc_chan.sv
// One Rx channel: activity synchroniser, IDLE/PEND/PEND_FORCE/HOLDOFF FSM, hold-off timer.
// RX_INTR_COALESCE_EN adds an activity-edge counter that can end hold-off early.
module rx_intr_chan
   import rx_intr_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             act_i,
   input  logic             notify_i,
   input  logic             buf_ready_i,
   input  logic             mask_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic             resend_i,
   input  logic             lock_i,
   input  logic             accept_i,
`ifdef RX_INTR_COALESCE_EN
   input  logic [7:0]       thr_i,
`endif
   output logic             req_o,
   output logic             ack_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   ch_state_e              state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       per_q;
   logic                   ack_q;
   logic                   act;
   logic                   go_hold;
   logic                   coal_done;

   assign act = sync_q[SYNC_STAGES-1];

`ifdef RX_INTR_COALESCE_EN
   logic       act_prev_q;
   logic [7:0] coal_q;
   assign coal_done = (thr_i != 8'd0) && (coal_q >= thr_i);
`else
   assign coal_done = 1'b0;
`endif

   // Once the arbiter has asserted our request, only acceptance may retire it.
   always_comb begin
      go_hold = 1'b0;
      case (state_q)
         IDLE:       go_hold = !resend_i && (act || notify_i) && !(en_i && !mask_i && buf_ready_i);
         PEND:       go_hold = lock_i ? accept_i : (!en_i || mask_i);
         PEND_FORCE: go_hold = accept_i;
         default:    go_hold = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         ack_q   <= 1'b0;
`ifdef RX_INTR_COALESCE_EN
         act_prev_q <= 1'b0;
         coal_q     <= 8'd0;
`endif
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(act_i);
         ack_q  <= 1'b0;
`ifdef RX_INTR_COALESCE_EN
         act_prev_q <= act;
         if (state_q == HOLDOFF && act && !act_prev_q && coal_q != 8'hFF)
            coal_q <= coal_q + 8'd1;
`endif
         if (go_hold) begin
            state_q <= HOLDOFF;
            cnt_q   <= '0;
            per_q   <= period_i;
`ifdef RX_INTR_COALESCE_EN
            coal_q  <= 8'd0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (resend_i) begin
                     ack_q   <= 1'b1;
                     state_q <= PEND_FORCE;
                  end else if (act || notify_i) begin
                     state_q <= PEND;
                  end
               end
               PEND, PEND_FORCE: ;
               HOLDOFF: begin
                  if (cnt_q == per_q || coal_done)
                     state_q <= IDLE;
                  else
                     cnt_q <= cnt_q + CNT_W'(1);
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign req_o = en_i && ((state_q == PEND && !mask_i) || state_q == PEND_FORCE);
   assign ack_o = ack_q;

endmodule

// File: rtl/rx_interrupt_gen_mc.sv
// Multi-channel Rx interrupt generator: per-channel FSMs, round-robin onto one cfg_interrupt handshake.
// Optional RX_INTR_COALESCE_EN adds coalesce_threshold for early hold-off exit.
module rx_interrupt_gen_mc
   import rx_intr_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   rx_interrupt_gen_mc_if.master cfg,
   input  logic [NUM_CH-1:0]     ch_activity,
   input  logic [NUM_CH-1:0]     ch_notify,
   input  logic [NUM_CH-1:0]     ch_buf_ready,
   input  logic [NUM_CH-1:0]     ch_mask,
   input  logic                  interrupts_enabled,
   input  logic [CNT_W-1:0]      interrupt_period,
   input  logic [NUM_CH-1:0]     resend_interrupt,
`ifdef RX_INTR_COALESCE_EN
   input  logic [7:0]            coalesce_threshold,
`endif
   output logic [NUM_CH-1:0]     resend_interrupt_ack
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   arb_state_e       arb_q;
   logic             cfg_n_q;
   logic [VEC_W-1:0] di_q;
   logic [IDX_W-1:0] last_grant_q;
   logic [IDX_W-1:0] grant_q;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] lock;
   logic [NUM_CH-1:0] accept;
   logic              found;
   logic [IDX_W-1:0]  sel;
   logic [IDX_W:0]    cand;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign lock[i]   = (arb_q == ARB_ASSERT) && (grant_q == IDX_W'(i));
      assign accept[i] = lock[i] && !cfg.cfg_interrupt_rdy_n;

      rx_intr_chan #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .act_i       (ch_activity[i]),
         .notify_i    (ch_notify[i]),
         .buf_ready_i (ch_buf_ready[i]),
         .mask_i      (ch_mask[i]),
         .en_i        (interrupts_enabled),
         .period_i    (interrupt_period),
         .resend_i    (resend_interrupt[i]),
         .lock_i      (lock[i]),
         .accept_i    (accept[i]),
`ifdef RX_INTR_COALESCE_EN
         .thr_i       (coalesce_threshold),
`endif
         .req_o       (req[i]),
         .ack_o       (resend_interrupt_ack[i])
      );
   end

   // Round-robin search starting just after the last accepted channel.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_CH))
            cand = cand - (IDX_W+1)'(NUM_CH);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         arb_q        <= ARB_IDLE;
         cfg_n_q      <= 1'b1;
         di_q         <= '0;
         last_grant_q <= IDX_W'(NUM_CH - 1);
         grant_q      <= '0;
      end else begin
         case (arb_q)
            ARB_IDLE: begin
               if (found) begin
                  grant_q <= sel;
                  cfg_n_q <= 1'b0;
                  di_q    <= VEC_W'(sel);
                  arb_q   <= ARB_ASSERT;
               end
            end
            ARB_ASSERT: begin
               if (!cfg.cfg_interrupt_rdy_n) begin
                  cfg_n_q      <= 1'b1;
                  last_grant_q <= grant_q;
                  arb_q        <= ARB_IDLE;
               end
            end
            default: arb_q <= ARB_IDLE;
         endcase
      end
   end

   assign cfg.cfg_interrupt_n  = cfg_n_q;
   assign cfg.cfg_interrupt_di = di_q;

endmodule

// File: tb/tb_rx_interrupt_gen_mc.sv
// Directed bench for rx_interrupt_gen_mc (NUM_CH=4, SYNC_STAGES=2); coalesce case only with RX_INTR_COALESCE_EN.
module tb_rx_interrupt_gen_mc;

   logic        clk;
   logic        reset;
   logic [3:0]  ch_activity;
   logic [3:0]  ch_notify;
   logic [3:0]  ch_buf_ready;
   logic [3:0]  ch_mask;
   logic        interrupts_enabled;
   logic [31:0] interrupt_period;
   logic [3:0]  resend_interrupt;
   logic [3:0]  resend_interrupt_ack;
`ifdef RX_INTR_COALESCE_EN
   logic [7:0]  coalesce_threshold;
`endif

   int n_chk;
   int n_bad;

   rx_interrupt_gen_mc_if intf();

   rx_interrupt_gen_mc #(
      .NUM_CH      (4),
      .CNT_W       (32),
      .SYNC_STAGES (2)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .cfg                  (intf),
      .ch_activity          (ch_activity),
      .ch_notify            (ch_notify),
      .ch_buf_ready         (ch_buf_ready),
      .ch_mask              (ch_mask),
      .interrupts_enabled   (interrupts_enabled),
      .interrupt_period     (interrupt_period),
      .resend_interrupt     (resend_interrupt),
`ifdef RX_INTR_COALESCE_EN
      .coalesce_threshold   (coalesce_threshold),
`endif
      .resend_interrupt_ack (resend_interrupt_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic cfg_n;
   logic [7:0] cfg_di;
   assign cfg_n  = intf.cfg_interrupt_n;
   assign cfg_di = intf.cfg_interrupt_di;

   logic exp_n  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   int   exp_di [7] = '{0, 3, 0, 0, 0, 2, 0};

   initial begin
      int lows;
      int seen;
      n_chk = 0;
      n_bad = 0;
      reset = 1'b1;
      ch_activity = '0;
      ch_notify = '0;
      ch_buf_ready = 4'hF;
      ch_mask = '0;
      interrupts_enabled = 1'b1;
      interrupt_period = 32'd10;
      resend_interrupt = '0;
      intf.cfg_interrupt_rdy_n = 1'b1;
`ifdef RX_INTR_COALESCE_EN
      coalesce_threshold = 8'd0;
`endif

      tick(3);
      chk("rst_cfg_n", 32'(cfg_n), 32'd1);
      chk("rst_di", 32'(cfg_di), 32'd0);
      chk("rst_ack", 32'(resend_interrupt_ack), 32'd0);
      reset = 1'b0;
      tick(2);

      // Activity pulse on ch1: request four edges later, then period+1 hold-off.
      ch_activity = 4'b0010;
      tick();
      ch_activity = '0;
      tick(2);
      chk("t1_not_yet", 32'(cfg_n), 32'd1);
      tick();
      chk("t1_req", 32'(cfg_n), 32'd0);
      chk("t1_di", 32'(cfg_di), 32'd1);
      tick(2);
      chk("t1_held", 32'(cfg_n), 32'd0);
      intf.cfg_interrupt_rdy_n = 1'b0;
      tick();
      intf.cfg_interrupt_rdy_n = 1'b1;
      chk("t1_accept", 32'(cfg_n), 32'd1);
      ch_activity = 4'b0010;
      lows = 0;
      repeat (12) begin
         tick();
         if (cfg_n == 1'b0) lows++;
      end
      chk("t1_holdoff_quiet", 32'(lows), 32'd0);
      tick();
      chk("t1_retrig", 32'(cfg_n), 32'd0);
      chk("t1_retrig_di", 32'(cfg_di), 32'd1);
      ch_activity = '0;
      intf.cfg_interrupt_rdy_n = 1'b0;
      tick();
      intf.cfg_interrupt_rdy_n = 1'b1;
      tick(15);

      // Make ch2 the last grant, then ch0/2/3 pend together: expect 3, 0, 2.
      interrupt_period = 32'd2;
      ch_notify = 4'b0100;
      tick();
      ch_notify = '0;
      tick();
      chk("t2_pre_req", 32'(cfg_n), 32'd0);
      chk("t2_pre_di", 32'(cfg_di), 32'd2);
      intf.cfg_interrupt_rdy_n = 1'b0;
      tick();
      intf.cfg_interrupt_rdy_n = 1'b1;
      tick(5);
      ch_notify = 4'b1101;
      intf.cfg_interrupt_rdy_n = 1'b0;
      for (int s = 0; s < 7; s++) begin
         tick();
         if (s == 0) ch_notify = '0;
         chk($sformatf("t2_n_%0d", s), 32'(cfg_n), 32'(exp_n[s]));
         if (exp_n[s] == 1'b0)
            chk($sformatf("t2_di_%0d", s), 32'(cfg_di), 32'(exp_di[s]));
      end
      intf.cfg_interrupt_rdy_n = 1'b1;
      tick(5);

      // Buffer not ready: no interrupt, hold-off still runs period+1 cycles.
      interrupt_period = 32'd5;
      ch_buf_ready = 4'b1101;
      ch_activity = 4'b0010;
      lows = 0;
      repeat (3) begin
         tick();
         if (cfg_n == 1'b0) lows++;
      end
      ch_buf_ready = 4'hF;
      repeat (7) begin
         tick();
         if (cfg_n == 1'b0) lows++;
      end
      chk("t3_no_req", 32'(lows), 32'd0);
      tick();
      chk("t3_req_after_holdoff", 32'(cfg_n), 32'd0);
      chk("t3_di", 32'(cfg_di), 32'd1);
      ch_activity = '0;
      intf.cfg_interrupt_rdy_n = 1'b0;
      tick();
      intf.cfg_interrupt_rdy_n = 1'b1;
      tick(10);

      // Forced resend on ch2 while disabled: ack now, request only once enabled.
      interrupts_enabled = 1'b0;
      resend_interrupt = 4'b0100;
      chk("t4_ack_pre", 32'(resend_interrupt_ack), 32'd0);
      tick();
      chk("t4_ack", 32'(resend_interrupt_ack), 32'h4);
      resend_interrupt = '0;
      tick();
      chk("t4_ack_gone", 32'(resend_interrupt_ack), 32'd0);
      lows = 0;
      repeat (5) begin
         tick();
         if (cfg_n == 1'b0) lows++;
      end
      chk("t4_no_req_disabled", 32'(lows), 32'd0);
      interrupts_enabled = 1'b1;
      tick();
      chk("t4_req", 32'(cfg_n), 32'd0);
      chk("t4_di", 32'(cfg_di), 32'd2);

      // Asserted request survives disable until accepted.
      interrupts_enabled = 1'b0;
      seen = 0;
      repeat (20) begin
         tick();
         if (cfg_n == 1'b1) seen++;
      end
      chk("t5_held_low", 32'(seen), 32'd0);
      intf.cfg_interrupt_rdy_n = 1'b0;
      tick();
      intf.cfg_interrupt_rdy_n = 1'b1;
      chk("t5_accept", 32'(cfg_n), 32'd1);
      interrupts_enabled = 1'b1;
      tick(8);

      // Reset in the middle of a handshake.
      ch_notify = 4'b0001;
      tick();
      ch_notify = '0;
      tick();
      chk("t5_req_ch0", 32'(cfg_n), 32'd0);
      reset = 1'b1;
      tick();
      chk("t5_rst_cfg_n", 32'(cfg_n), 32'd1);
      chk("t5_rst_di", 32'(cfg_di), 32'd0);
      reset = 1'b0;
      tick(3);
      chk("t5_no_req_after_rst", 32'(cfg_n), 32'd1);

`ifdef RX_INTR_COALESCE_EN
      // Three activity edges during a long hold-off end it early.
      interrupt_period = 32'd1000;
      coalesce_threshold = 8'd3;
      intf.cfg_interrupt_rdy_n = 1'b0;
      ch_notify = 4'b0010;
      tick();
      ch_notify = '0;
      tick();
      chk("c_req", 32'(cfg_n), 32'd0);
      tick();
      chk("c_accept", 32'(cfg_n), 32'd1);
      intf.cfg_interrupt_rdy_n = 1'b1;
      repeat (2) begin
         ch_activity = 4'b0010;
         tick(2);
         ch_activity = '0;
         tick(2);
      end
      ch_activity = 4'b0010;
      seen = 0;
      for (int w = 0; w < 40 && seen == 0; w++) begin
         tick();
         if (cfg_n == 1'b0) seen = 1;
      end
      chk("c_early_req", 32'(seen), 32'd1);
      chk("c_early_di", 32'(cfg_di), 32'd1);
      ch_activity = '0;
      intf.cfg_interrupt_rdy_n = 1'b0;
      tick();
      intf.cfg_interrupt_rdy_n = 1'b1;
      tick(2);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
